systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Front-end skew generator for the backprop systolic stack. Accepts whole row vectors over a valid/ready handshake. Emits them as a diagonally skewed `z_to_z` stream: lane k is delayed by k cycles. It also generates the `reset_counter_in` pulse that starts accumulation in the array, then drains the skew with zeros at the end of each block. It is the producer end of the `z_to_z` / `reset_counter_in` interface that the systolic array consumes.

## Interface
- `data_size`, 16, bit width of one lane element (fixed-point, passed through untouched).
- `size`, 3, number of lanes; must match the systolic array `size`; legal range ≥ 1.
- `clk` input 1: single clock, all state updates on posedge.
- `reset_n` input 1: reset is asynchronous and active-low; forces all state and outputs to reset values immediately.
- `in_row` input data_size*size: row vector; lane k = bits [data_size*(k+1)-1 : data_size*k].
- `in_valid` input 1: `in_row`/`in_last` valid.
- `in_last` input 1: accompanying row is the last row of the current block.
- `in_ready` output 1: feeder can accept a row this cycle.
- `z_to_z` output data_size*size: skewed stream to the array, registered.
- `reset_counter_in` output 1: one-cycle pulse marking the first row of a block, registered.
- `block_done` output 1: one-cycle pulse when the last lane of the last row of a block leaves.
- `row_count` output 32: rows accepted in the current block.

## Operation
- Accept = `in_valid & in_ready` at a posedge.
- Lane pipeline: lane k has a k-stage shift register behind the output register. Lane 0 passes straight to the output register.
- Every cycle each lane advances one stage. If no row is accepted, a zero element is inserted at lane input.
- FSM states:
  - IDLE: `in_ready`=1. An accept moves to STREAM, or to DRAIN if `in_last`=1. The accept is a block start.
  - STREAM: `in_ready`=1. An accept with `in_last`=1 moves to DRAIN. Cycles without an accept insert zero rows; skew is preserved and the FSM stays in STREAM.
  - DRAIN: `in_ready`=0. A down-counter loaded with size-1 on entry decrements each cycle. Return to IDLE when it reaches 0. With size=1, DRAIN lasts 0 cycles (go IDLE directly).
- Block start (first accept after IDLE):
  - `reset_counter_in` pulses in the cycle that the row's lane 0 appears on `z_to_z`.
  - `row_count` loads 1.
- Later accepts in the block increment `row_count`. It saturates at 2^32-1 and holds its value after the block until the next block start.
- A single-row block (`in_last` on the first accept) both pulses `reset_counter_in` and enters DRAIN.
- `in_valid` while `in_ready`=0 is ignored. The source must hold `in_row`; no data loss.
- `reset_n` low mid-block aborts the block:
  - all lanes are zeroed;
  - no `block_done` is issued;
  - FSM returns to IDLE.

## Timing
- Reset values: `z_to_z`=0, `reset_counter_in`=0, `block_done`=0, `row_count`=0, `in_ready`=1 (IDLE), all shift stages 0.
- Row accepted at posedge t:
  - lane 0 is on `z_to_z` during cycle t+1;
  - lane k is on `z_to_z` during cycle t+1+k;
  - all other cycles show 0 for that row's slots unless another row occupies them.
- `reset_counter_in` is high exactly during cycle t+1 for a block-start accept at t.
- Last row accepted at t:
  - `in_ready` is 0 for cycles t+1 … t+size-1;
  - IDLE is reached and `in_ready`=1 at cycle t+size;
  - `block_done` is high exactly during cycle t+size, coincident with lane size-1 of the last row.
- Back-to-back blocks: the earliest next accept is at the posedge ending cycle t+size. Its lane 0 appears at t+size+1, so streams never overlap.
- Throughput: 1 row/cycle in STREAM; block overhead of size-1 bubble cycles.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → all outputs 0, `in_ready`=1; release → still 0 until first accept.
- Single 3-row block (size=3, data_size=16), rows {1,2,3},{4,5,6},{7,8,9} (lane0 first) accepted at t=0,1,2 with `in_last` on the third:
  - `z_to_z` lanes (0,1,2) for cycles 1..5 = (1,0,0),(4,2,0),(7,5,3),(0,8,6),(0,0,9);
  - `reset_counter_in` high at cycle 1 only;
  - `block_done` high at cycle 5;
  - `in_ready` low in cycles 3–4;
  - `row_count`=3.
- Gap insertion: same rows, `in_valid` dropped for 1 cycle after row 1 → a zero diagonal appears between rows, skew intact, `row_count`=3.
- Single-row block {10,20,30}, `in_last`=1 at t=0:
  - `reset_counter_in` high at cycle 1;
  - lane outputs 10 @1, 20 @2, 30 @3;
  - `block_done` @3;
  - next accept allowed at t=3.
- Backpressure: `in_valid` held high during DRAIN with row {99,99,99} → not accepted until `in_ready`=1, then it starts a new block with a fresh `reset_counter_in` pulse.
- Async reset mid-block: assert `reset_n`=0 between row 2 and row 3 → outputs zero immediately, no `block_done`; after release a new block behaves as in the 3-row scenario.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts row vectors and emits them diagonally skewed (lane k delayed k cycles)
// with a block-start pulse for the array and a zero drain at the end of each block.
module systolic_feeder #(
  parameter int DATA_SIZE = 16,
  parameter int SIZE      = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_SIZE*SIZE-1:0] in_row,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [DATA_SIZE*SIZE-1:0] z_to_z,
  output logic                      reset_counter_in,
  output logic                      block_done,
  output logic [31:0]               row_count
);
  localparam int CW = $clog2(SIZE + 1);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rci_q, rci_d, bd_q, bd_d;
  logic [31:0] rc_q, rc_d;
  logic accept, start;
  assign in_ready = state_q != DRAIN;
  assign accept = in_valid & in_ready;
  assign start = accept & (state_q == IDLE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == DRAIN) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q <= CW'(1)) state_d = IDLE;
    end else if (accept) begin
      state_d = !in_last ? STREAM : (SIZE == 1) ? IDLE : DRAIN;
      cnt_d = CW'(SIZE - 1);
    end
    rci_d = start;
    // the final lane leaves as the drain counter expires; size 1 has no drain at all
    bd_d = (state_q == DRAIN && cnt_q == CW'(1)) || (accept && in_last && SIZE == 1);
    rc_d = start ? 32'd1 : (accept && rc_q != '1) ? rc_q + 32'd1 : rc_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rci_q <= 1'b0;
      bd_q <= 1'b0;
      rc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rci_q <= rci_d;
      bd_q <= bd_d;
      rc_q <= rc_d;
    end
  end
  assign reset_counter_in = rci_q;
  assign block_done = bd_q;
  assign row_count = rc_q;
  // lane g: g skew stages followed by the output register (index g)
  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    logic [g:0][DATA_SIZE-1:0] sr_q, sr_d;
    always_comb begin
      sr_d[0] = accept ? in_row[g*DATA_SIZE +: DATA_SIZE] : '0;
      for (int i = 1; i <= g; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sr_q <= '0;
      else sr_q <= sr_d;
    end
    assign z_to_z[g*DATA_SIZE +: DATA_SIZE] = sr_q[g];
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed stimulus with hand-computed per-cycle expectations,
// queued by the driver and checked by an independent monitor one step after each posedge.
module tb_systolic_feeder;
  typedef struct packed {
    logic [47:0] z;
    logic        rci;
    logic        bd;
    logic        rdy;
    logic [31:0] rc;
  } obs_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [47:0] in_row = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [47:0] z_to_z;
  logic        reset_counter_in;
  logic        block_done;
  logic [31:0] row_count;
  obs_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  systolic_feeder #(.DATA_SIZE(16), .SIZE(3)) dut (
    .clk(clk), .reset_n(reset_n), .in_row(in_row), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .z_to_z(z_to_z), .reset_counter_in(reset_counter_in),
    .block_done(block_done), .row_count(row_count)
  );
  always #5 clk = ~clk;
  function automatic obs_t actual();
    return '{z: z_to_z, rci: reset_counter_in, bd: block_done, rdy: in_ready, rc: row_count};
  endfunction
  task automatic check(input string name, input obs_t e);
    obs_t a = actual();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got z=%h rci=%b bd=%b rdy=%b rc=%0d, want z=%h rci=%b bd=%b rdy=%b rc=%0d",
               name, a.z, a.rci, a.bd, a.rdy, a.rc, e.z, e.rci, e.bd, e.rdy, e.rc);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check("cycle", exp_q.pop_front());
  end
  // drive one row before a posedge and queue the outputs expected in the cycle after it
  task automatic step(input logic v, input logic l, input logic [15:0] a, b, c,
                      input logic [15:0] ea, eb, ec, input logic erci, ebd, erdy,
                      input logic [31:0] erc);
    @(negedge clk);
    in_valid = v;
    in_last = l;
    in_row = {c, b, a};
    exp_q.push_back('{z: {ec, eb, ea}, rci: erci, bd: ebd, rdy: erdy, rc: erc});
  endtask
  task automatic idle(input logic [31:0] erc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, erc);
  endtask
  task automatic three_rows();
    step(1, 0, 1, 2, 3, 1, 0, 0, 1, 0, 1, 1);
    step(1, 0, 4, 5, 6, 4, 2, 0, 0, 0, 1, 2);
    step(1, 1, 7, 8, 9, 7, 5, 3, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 8, 6, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 3);
    idle(3);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish within budget");
    $fatal(1, "timeout");
  end
  initial begin
    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_last = 1'($urandom);
      in_row = {$urandom, $urandom};
      #1 check("reset_hold", '{z: '0, rci: 0, bd: 0, rdy: 1, rc: 0});
    end
    @(negedge clk);
    in_valid = 0;
    reset_n = 1'b1;
    idle(0);
    idle(0);
    three_rows();
    // one-cycle gap after the first row
    step(1, 0, 1, 2, 3, 1, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1);
    step(1, 0, 4, 5, 6, 4, 0, 3, 0, 0, 1, 2);
    step(1, 1, 7, 8, 9, 7, 5, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 8, 6, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 3);
    idle(3);
    // single-row block, then a row held during drain starts the next block
    step(1, 1, 10, 20, 30, 10, 0, 0, 1, 0, 0, 1);
    step(1, 1, 99, 99, 99, 0, 20, 0, 0, 0, 0, 1);
    step(1, 1, 99, 99, 99, 0, 0, 30, 0, 1, 1, 1);
    step(1, 1, 99, 99, 99, 99, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 99, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 99, 0, 1, 1, 1);
    idle(1);
    // async reset between row 2 and row 3
    step(1, 0, 1, 2, 3, 1, 0, 0, 1, 0, 1, 1);
    step(1, 0, 4, 5, 6, 4, 2, 0, 0, 0, 1, 2);
    @(negedge clk);
    in_valid = 1'b1;
    in_row = {16'd9, 16'd8, 16'd7};
    #2 reset_n = 1'b0;
    #1 check("async_reset_now", '{z: '0, rci: 0, bd: 0, rdy: 1, rc: 0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("async_reset_hold", '{z: '0, rci: 0, bd: 0, rdy: 1, rc: 0});
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    idle(0);
    three_rows();
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
